// File: rtl/ttt_move_controller.sv
// Tic-tac-toe sequencer: debounces move requests, checks legality, commits, scores win/draw.
// Commit visible 1 cycle after CHECK and result 2 cycles after; requests arriving while busy wait in a 1-deep pending slot.
module ttt_move_controller #(
    parameter int         STABLE_CYCLES = 2,
    parameter logic [1:0] FIRST_PLAYER  = 2'b01
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_move_en,
    input  logic [1:0] i_move_player,
    input  logic [3:0] i_move_cell,
    input  logic       i_new_game,
    output logic [8:0] o_board_p1,
    output logic [8:0] o_board_p2,
    output logic [1:0] o_turn,
    output logic       o_move_ok,
    output logic       o_move_bad,
    output logic       o_busy,
    output logic       o_game_over,
    output logic [1:0] o_winner,
    output logic [2:0] o_win_line,
    output logic [2:0] o_score_p1,
    output logic [2:0] o_score_p2
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // Line masks, index 7 first: bit i-1 represents cell i.
    localparam logic [7:0][8:0] LINES = {
        9'b001010100, 9'b100010001, 9'b100100100, 9'b010010010,
        9'b001001001, 9'b111000000, 9'b000111000, 9'b000000111
    };

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EVAL, S_OVER} state_t;

    state_t          r_state, w_state_nxt;
    logic [5:0]      r_prev_tuple;
    logic            r_prev_en;
    logic [CW-1:0]   r_cnt;
    logic            r_fired;
    logic            r_pend;
    logic [1:0]      r_pend_player, r_cur_player;
    logic [3:0]      r_pend_cell, r_cur_cell;
    logic [8:0]      r_board_p1, r_board_p2;
    logic [1:0]      r_turn, r_next_first, r_winner;
    logic            r_move_ok, r_move_bad, r_game_over;
    logic [2:0]      r_win_line, r_score_p1, r_score_p2;

    logic [5:0]      w_tuple;
    logic            w_same, w_qual;
    logic [CW-1:0]   w_cnt_nxt;
    logic [8:0]      w_cell_mask, w_mover_board;
    logic            w_legal, w_win, w_full;
    logic [2:0]      w_win_idx;

    // Qualifier: a tuple fires once per continuous hold.
    assign w_tuple   = {i_move_player, i_move_cell};
    assign w_same    = i_move_en & r_prev_en & (w_tuple == r_prev_tuple);
    assign w_cnt_nxt = !w_same ? '0 : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1));
    assign w_qual    = i_move_en & ~(w_same & r_fired) & (w_cnt_nxt == CNT_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_tuple <= '0;
            r_prev_en    <= 1'b0;
            r_cnt        <= '0;
            r_fired      <= 1'b0;
        end else begin
            r_prev_tuple <= w_tuple;
            r_prev_en    <= i_move_en;
            r_cnt        <= w_cnt_nxt;
            r_fired      <= i_move_en & ((w_same & r_fired) | w_qual);
        end
    end

    // A fresh qualification beats consumption, so an overlapping request is never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend        <= 1'b0;
            r_pend_player <= 2'b00;
            r_pend_cell   <= 4'd0;
        end else if (i_new_game) begin
            r_pend <= 1'b0;
        end else if (w_qual) begin
            r_pend        <= 1'b1;
            r_pend_player <= i_move_player;
            r_pend_cell   <= i_move_cell;
        end else if (r_state == S_IDLE || r_state == S_OVER) begin
            r_pend <= 1'b0;
        end
    end

    always_comb begin
        w_cell_mask = '0;
        if (r_cur_cell >= 4'd1 && r_cur_cell <= 4'd9)
            w_cell_mask = 9'(1) << (r_cur_cell - 4'd1);
        w_legal = (r_cur_player == r_turn) && (w_cell_mask != '0) &&
                  (((r_board_p1 | r_board_p2) & w_cell_mask) == '0);

        w_mover_board = (r_cur_player == 2'b01) ? r_board_p1 : r_board_p2;
        w_win     = 1'b0;
        w_win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if ((w_mover_board & LINES[i]) == LINES[i]) begin
                w_win     = 1'b1;
                w_win_idx = 3'(i);
            end
        end
        w_full = &(r_board_p1 | r_board_p2);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE:  if (r_pend) w_state_nxt = S_CHECK;
            S_CHECK: begin
                o_busy      = 1'b1;
                w_state_nxt = w_legal ? S_EVAL : S_IDLE;
            end
            S_EVAL: begin
                o_busy      = 1'b1;
                w_state_nxt = (w_win || w_full) ? S_OVER : S_IDLE;
            end
            S_OVER:  w_state_nxt = S_OVER;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_new_game) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_board_p1   <= '0;
            r_board_p2   <= '0;
            r_turn       <= FIRST_PLAYER;
            r_next_first <= FIRST_PLAYER;
            r_winner     <= 2'b00;
            r_win_line   <= 3'd0;
            r_game_over  <= 1'b0;
            r_move_ok    <= 1'b0;
            r_move_bad   <= 1'b0;
            r_score_p1   <= 3'd0;
            r_score_p2   <= 3'd0;
            r_cur_player <= 2'b00;
            r_cur_cell   <= 4'd0;
        end else begin
            r_move_ok  <= 1'b0;
            r_move_bad <= 1'b0;
            if (i_new_game) begin
                r_board_p1   <= '0;
                r_board_p2   <= '0;
                r_winner     <= 2'b00;
                r_win_line   <= 3'd0;
                r_game_over  <= 1'b0;
                r_next_first <= r_next_first ^ 2'b11;
                r_turn       <= r_next_first ^ 2'b11;
            end else begin
                case (r_state)
                    S_IDLE: if (r_pend) begin
                        r_cur_player <= r_pend_player;
                        r_cur_cell   <= r_pend_cell;
                    end
                    S_CHECK: if (w_legal) begin
                        if (r_cur_player == 2'b01) r_board_p1 <= r_board_p1 | w_cell_mask;
                        else                       r_board_p2 <= r_board_p2 | w_cell_mask;
                        r_move_ok <= 1'b1;
                    end else begin
                        r_move_bad <= 1'b1;
                    end
                    S_EVAL: if (w_win) begin
                        r_winner    <= r_cur_player;
                        r_win_line  <= w_win_idx;
                        r_game_over <= 1'b1;
                        if (r_cur_player == 2'b01 && r_score_p1 != 3'd7) r_score_p1 <= r_score_p1 + 3'd1;
                        if (r_cur_player == 2'b10 && r_score_p2 != 3'd7) r_score_p2 <= r_score_p2 + 3'd1;
                    end else if (w_full) begin
                        r_winner    <= 2'b11;
                        r_game_over <= 1'b1;
                    end else begin
                        r_turn <= r_turn ^ 2'b11;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_board_p1  = r_board_p1;
    assign o_board_p2  = r_board_p2;
    assign o_turn      = r_turn;
    assign o_move_ok   = r_move_ok;
    assign o_move_bad  = r_move_bad;
    assign o_game_over = r_game_over;
    assign o_winner    = r_winner;
    assign o_win_line  = r_win_line;
    assign o_score_p1  = r_score_p1;
    assign o_score_p2  = r_score_p2;

endmodule
